// File: rtl/router_pkg.sv
// Shared types and constants for the packet router controller.
// Holds the FSM state enum, header field widths and a port-select helper.
package router_pkg;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;

    // Header address value that names no output port.
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY
    } state_e;

    // Pick one of the three per-port flags by address.
    // The invalid address selects nothing.
    function automatic logic port_sel(
        input logic [2:0]        v,
        input logic [ADDR_W-1:0] a
    );
        logic r;
        r = 1'b0;
        case (a)
            2'd0:    r = v[0];
            2'd1:    r = v[1];
            2'd2:    r = v[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/router_parity.sv
// Running XOR of the bytes of one packet.
// Ports: clk; clr_i (sync clear, wins); en_i (fold data_i in); data_i; acc_o.
module router_parity (
    input  logic       clk,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [7:0] acc_o
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q ^ data_i;
        end
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/router_ctrl.sv
// Router packet controller: decodes the header, sequences payload and
// parity bytes into the selected FIFO, and handles full stalls and aborts.
// Inputs : clk, reset (sync, active high), pkt_valid, data_in[7:0],
//          fifo_full, empty_0..2, soft_reset_0..2.
// Outputs: detect_add, write_enb_reg, dout[7:0], lfd_state, busy,
//          err, pkt_done.
// Option : ROUTER_PARITY_CHK_EN enables the parity accumulator and err.
module router_ctrl
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic       fifo_full,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    output logic       detect_add,
    output logic       write_enb_reg,
    output logic [7:0] dout,
    output logic       lfd_state,
    output logic       busy,
    output logic       err,
    output logic       pkt_done
);

    state_e state_q;
    state_e state_d;

    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_d;
    logic [7:0]       header_q;
    logic [7:0]       header_d;
    logic [7:0]       held_q;
    logic [7:0]       held_d;
    logic [7:0]       dout_q;
    logic [7:0]       dout_d;
    logic             we_q;
    logic             we_d;
    logic             lfd_q;
    logic             lfd_d;

    logic [ADDR_W-1:0] hdr_addr;
    logic [LEN_W-1:0]  hdr_len;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        empty_v;
    logic [2:0]        sr_v;
    logic              empty_hdr;
    logic              empty_cur;
    logic              abort;
    logic              hdr_ok;
    logic              busy_c;
    logic              par_en;
    logic              det_c;

    assign hdr_addr = data_in[ADDR_W-1:0];
    assign hdr_len  = data_in[7:ADDR_W];
    assign addr_q   = header_q[ADDR_W-1:0];

    assign empty_v = {empty_2, empty_1, empty_0};
    assign sr_v    = {soft_reset_2, soft_reset_1, soft_reset_0};

    // The header byte addresses a port directly; later states use the
    // latched header address.
    assign empty_hdr = port_sel(empty_v, hdr_addr);
    assign empty_cur = port_sel(empty_v, addr_q);

    // A flush of the port this packet is going to kills the packet.
    assign abort = (state_q != DECODE_ADDRESS) && port_sel(sr_v, addr_q);

    assign hdr_ok = pkt_valid && (hdr_addr != ADDR_INVALID);

    always_comb begin
        busy_c = 1'b1;
        unique case (state_q)
            DECODE_ADDRESS: busy_c = 1'b0;
            LOAD_DATA:      busy_c = fifo_full;
            LOAD_PARITY:    busy_c = 1'b0;
            default:        busy_c = 1'b1;
        endcase
        // Never claim a byte in a cycle where it would be discarded.
        if (abort) begin
            busy_c = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        header_d = header_q;
        held_d   = held_q;
        dout_d   = dout_q;
        we_d     = 1'b0;
        lfd_d    = 1'b0;
        par_en   = 1'b0;
        det_c    = 1'b0;

        if (abort) begin
            state_d = DECODE_ADDRESS;
            count_d = '0;
        end else begin
            unique case (state_q)
                DECODE_ADDRESS: begin
                    if (hdr_ok) begin
                        det_c    = 1'b1;
                        header_d = data_in;
                        count_d  = hdr_len;
                        par_en   = 1'b1;
                        if (empty_hdr) begin
                            state_d = LOAD_FIRST_DATA;
                            we_d    = 1'b1;
                            dout_d  = data_in;
                            lfd_d   = 1'b1;
                        end else begin
                            state_d = WAIT_TILL_EMPTY;
                        end
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (empty_cur) begin
                        state_d = LOAD_FIRST_DATA;
                        we_d    = 1'b1;
                        dout_d  = header_q;
                        lfd_d   = 1'b1;
                    end
                end
                LOAD_FIRST_DATA: begin
                    state_d = (count_q == '0) ? LOAD_PARITY
                                              : LOAD_DATA;
                end
                LOAD_DATA: begin
                    if (fifo_full) begin
                        state_d = FIFO_FULL_STATE;
                    end else if (pkt_valid) begin
                        we_d   = 1'b1;
                        dout_d = data_in;
                        held_d = data_in;
                        par_en = 1'b1;
                        if (count_q != '0) begin
                            count_d = count_q - LEN_W'(1);
                        end
                        if (count_q <= LEN_W'(1)) begin
                            state_d = LOAD_PARITY;
                        end
                    end
                end
                FIFO_FULL_STATE: begin
                    // The byte presented while full was refused;
                    // present it again once space frees up.
                    if (!fifo_full) begin
                        state_d = LOAD_AFTER_FULL;
                        we_d    = 1'b1;
                        dout_d  = held_q;
                    end
                end
                LOAD_AFTER_FULL: begin
                    state_d = (count_q == '0) ? LOAD_PARITY
                                              : LOAD_DATA;
                end
                LOAD_PARITY: begin
                    if (pkt_valid) begin
                        we_d    = 1'b1;
                        dout_d  = data_in;
                        par_en  = 1'b1;
                        state_d = CHECK_PARITY;
                    end
                end
                CHECK_PARITY: begin
                    state_d = DECODE_ADDRESS;
                end
                default: begin
                    state_d = DECODE_ADDRESS;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= DECODE_ADDRESS;
            count_q  <= '0;
            header_q <= '0;
            held_q   <= '0;
            dout_q   <= '0;
            we_q     <= 1'b0;
            lfd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            header_q <= header_d;
            held_q   <= held_d;
            dout_q   <= dout_d;
            we_q     <= we_d;
            lfd_q    <= lfd_d;
        end
    end

    assign detect_add    = det_c;
    assign write_enb_reg = we_q;
    assign dout          = dout_q;
    assign lfd_state     = lfd_q;
    assign busy          = busy_c;
    assign pkt_done      = (state_q == CHECK_PARITY) && !abort;

`ifdef ROUTER_PARITY_CHK_EN
    logic       par_clr;
    logic [7:0] par_acc;

    // The parity byte is folded in too, so a good packet XORs to zero.
    assign par_clr = reset || abort || (state_q == CHECK_PARITY);

    router_parity u_parity (
        .clk    (clk),
        .clr_i  (par_clr),
        .en_i   (par_en),
        .data_i (data_in),
        .acc_o  (par_acc)
    );

    assign err = pkt_done && (par_acc != 8'h00);
`else
    logic par_en_unused;
    assign par_en_unused = par_en;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_ctrl.sv
// Scoreboard bench for router_ctrl: directed packets push expected FIFO
// writes and pkt_done/err outcomes; a negedge monitor pops and compares.
module tb_router_ctrl;

`ifdef ROUTER_PARITY_CHK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       empty_0, empty_1, empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       detect_add, write_enb_reg, lfd_state;
    logic       busy, err, pkt_done;
    logic [7:0] dout;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] exp_wr[$];
    logic       exp_err[$];

    always #5 clk = ~clk;

    router_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .empty_0       (empty_0),
        .empty_1       (empty_1),
        .empty_2       (empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .detect_add    (detect_add),
        .write_enb_reg (write_enb_reg),
        .dout          (dout),
        .lfd_state     (lfd_state),
        .busy          (busy),
        .err           (err),
        .pkt_done      (pkt_done)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_w(input logic l, input logic [7:0] b);
        exp_wr.push_back({l, b});
    endtask

    // Monitor: a write lands only when the FIFO is not full.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (write_enb_reg === 1'b1 && fifo_full === 1'b0) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wr_extra: got %0h expected none", dout);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr", {23'd0, lfd_state, dout}, {23'd0, e});
                end
            end
            if (pkt_done === 1'b1) begin
                if (exp_err.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done_extra: got pkt_done expected none");
                end else begin
                    chk("err", err, exp_err.pop_front());
                end
            end else begin
                chk("err_idle", err, 0);
            end
        end
    end

    task automatic drive_byte(input logic [7:0] b);
        bit took;
        took = 1'b0;
        pkt_valid = 1'b1;
        data_in = b;
        for (int i = 0; i < 60 && !took; i++) begin
            @(negedge clk);
            took = !busy;
            @(posedge clk);
            #1;
        end
        pkt_valid = 1'b0;
        if (!took) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: byte %0h never accepted", b);
        end
    endtask

    task automatic send_hdr(input logic [7:0] h, input logic det);
        pkt_valid = 1'b1;
        data_in = h;
        @(negedge clk);
        chk("detect_add", detect_add, det);
        chk("hdr_busy", busy, 0);
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (exp_wr.size() == 0 && exp_err.size() == 0) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_left"}, exp_wr.size() + exp_err.size(), 0);
    endtask

    task automatic outs_zero(input string name);
        @(negedge clk);
        chk(name, {detect_add, write_enb_reg, dout, lfd_state,
                   busy, err, pkt_done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        pkt_valid = 1'b0;
        data_in = 8'h00;
        fifo_full = 1'b0;
        empty_0 = 1'b1;
        empty_1 = 1'b1;
        empty_2 = 1'b1;
        soft_reset_0 = 1'b0;
        soft_reset_1 = 1'b0;
        soft_reset_2 = 1'b0;
        repeat (2) @(posedge clk);
        outs_zero("rst_outs");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Normal packet: 0D ^ 11 ^ 22 ^ 33 = 0D.
        exp_w(1, 8'h0D); exp_w(0, 8'h11); exp_w(0, 8'h22);
        exp_w(0, 8'h33); exp_w(0, 8'h0D);
        exp_err.push_back(1'b0);
        send_hdr(8'h0D, 1);
        drive_byte(8'h11); drive_byte(8'h22);
        drive_byte(8'h33); drive_byte(8'h0D);
        drain("normal");

        // Parity error.
        exp_w(1, 8'h0D); exp_w(0, 8'h11); exp_w(0, 8'h22);
        exp_w(0, 8'h33); exp_w(0, 8'hFF);
        exp_err.push_back(PCHK);
        send_hdr(8'h0D, 1);
        drive_byte(8'h11); drive_byte(8'h22);
        drive_byte(8'h33); drive_byte(8'hFF);
        drain("par_err");

        // Full stall after the second payload byte.
        exp_w(1, 8'h0D); exp_w(0, 8'h11); exp_w(0, 8'h22);
        exp_w(0, 8'h33); exp_w(0, 8'h0D);
        exp_err.push_back(1'b0);
        send_hdr(8'h0D, 1);
        drive_byte(8'h11); drive_byte(8'h22);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_busy", busy, 1);
            chk("stall_we", write_enb_reg, (i == 0) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        fifo_full = 1'b0;
        drive_byte(8'h33); drive_byte(8'h0D);
        drain("stall");

        // Wait till empty on port 2: 06 ^ A5 = A3.
        empty_2 = 1'b0;
        exp_w(1, 8'h06); exp_w(0, 8'hA5); exp_w(0, 8'hA3);
        exp_err.push_back(1'b0);
        send_hdr(8'h06, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_busy", busy, 1);
            chk("wait_we", write_enb_reg, 0);
            @(posedge clk);
            #1;
        end
        empty_2 = 1'b1;
        @(negedge clk);
        chk("wait_we_last", write_enb_reg, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wait_hdr_we", write_enb_reg, 1);
        chk("wait_hdr_lfd", lfd_state, 1);
        chk("wait_hdr_busy", busy, 1);
        @(posedge clk);
        #1;
        drive_byte(8'hA5); drive_byte(8'hA3);
        drain("wait");

        // Soft reset of port 1 mid-payload, then an immediate new header.
        exp_w(1, 8'h11); exp_w(0, 8'h5A);
        send_hdr(8'h11, 1);
        drive_byte(8'h5A);
        soft_reset_1 = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 1);
        chk("abort_done", pkt_done, 0);
        @(posedge clk);
        #1;
        soft_reset_1 = 1'b0;
        // 08 ^ 01 ^ 02 = 0B; detect_add proves the FSM is decoding.
        exp_w(1, 8'h08); exp_w(0, 8'h01); exp_w(0, 8'h02);
        exp_w(0, 8'h0B);
        exp_err.push_back(1'b0);
        send_hdr(8'h08, 1);
        drive_byte(8'h01); drive_byte(8'h02); drive_byte(8'h0B);
        drain("abort");

        // Invalid address 3 is dropped.
        send_hdr(8'h0F, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drop_busy", busy, 0);
            chk("drop_we", write_enb_reg, 0);
            @(posedge clk);
            #1;
        end
        drain("drop");

        // Zero-length packet: header then parity only.
        exp_w(1, 8'h01); exp_w(0, 8'h01);
        exp_err.push_back(1'b0);
        send_hdr(8'h01, 1);
        drive_byte(8'h01);
        drain("len0");

        // Reset mid-packet.
        exp_w(1, 8'h0D); exp_w(0, 8'h11);
        send_hdr(8'h0D, 1);
        drive_byte(8'h11);
        reset = 1'b1;
        @(posedge clk);
        #1;
        outs_zero("rst_mid");
        @(posedge clk);
        #1;
        reset = 1'b0;
        drain("rst_mid");

        // Recovery after reset.
        exp_w(1, 8'h0D); exp_w(0, 8'h11); exp_w(0, 8'h22);
        exp_w(0, 8'h33); exp_w(0, 8'h0D);
        exp_err.push_back(1'b0);
        send_hdr(8'h0D, 1);
        drive_byte(8'h11); drive_byte(8'h22);
        drive_byte(8'h33); drive_byte(8'h0D);
        drain("recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/router_ctrl.md
ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 pkt_valid  input  1  source has a byte on data_in.
REQ-004 data_in  input  8  packet byte: header {len[5:0], addr[1:0]}, then len payload bytes, then parity byte.
REQ-005 fifo_full  input  1  selected output FIFO full, from the sync block.
REQ-006 empty_0, empty_1, empty_2  input  1 each  per-port FIFO empty flags.
REQ-007 soft_reset_0, soft_reset_1, soft_reset_2  input  1 each  per-port timeout flush.
REQ-008 detect_add  output  1  header address is valid this cycle; sync block latches data_in[1:0].
REQ-009 write_enb_reg  output  1  write dout into the selected FIFO this cycle.
REQ-010 dout  output  8  registered byte to the FIFOs.
REQ-011 lfd_state  output  1  dout is a header byte.
REQ-012 busy  output  1  source must hold data_in; no byte is accepted.
REQ-013 err  output  1  one-cycle pulse on parity mismatch.
REQ-014 pkt_done  output  1  one-cycle pulse when the parity byte has been written.

Function
REQ-015 Byte accepted: the controller SHALL accept a byte only in a cycle where pkt_valid=1 and busy=0.
REQ-016 States: the FSM SHALL have exactly these states: DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY.
REQ-017 DECODE_ADDRESS (busy=0):
- pkt_valid=1 and addr=3: drop the byte, stay in DECODE_ADDRESS, detect_add=0.
- pkt_valid=1 and addr<3: detect_add=1 and latch header and len; go to LOAD_FIRST_DATA if empty_addr=1, otherwise go to WAIT_TILL_EMPTY.
REQ-018 WAIT_TILL_EMPTY (busy=1): go to LOAD_FIRST_DATA in the cycle after empty_addr=1.
REQ-019 LOAD_FIRST_DATA (busy=1): write_enb_reg=1, dout=header, lfd_state=1; go to LOAD_DATA, or to LOAD_PARITY if len=0.
REQ-020 LOAD_DATA (busy=fifo_full):
- Each accepted byte is registered to dout with write_enb_reg=1 and decrements the remaining-count.
- Accepting the byte that reaches count 0 moves the FSM to LOAD_PARITY.
- fifo_full=1 moves the FSM to FIFO_FULL_STATE; the in-flight byte is held.
REQ-021 FIFO_FULL_STATE (busy=1, write_enb_reg=0): go to LOAD_AFTER_FULL on fifo_full=0.
REQ-022 LOAD_AFTER_FULL (busy=1): rewrite the held byte with write_enb_reg=1; go to LOAD_PARITY if count=0, otherwise go to LOAD_DATA.
REQ-023 LOAD_PARITY (busy=0): accept the parity byte, write it, go to CHECK_PARITY.
REQ-024 CHECK_PARITY (busy=1): pulse pkt_done; pulse err if the parity byte differs from the XOR of header and payload; return to DECODE_ADDRESS.
REQ-025 Pipeline latency: an accepted byte SHALL appear on dout with write_enb_reg=1 exactly one cycle later, unless fifo_full holds it.
REQ-026 Soft-reset abort: soft_reset of the addressed port in any non-DECODE state SHALL return the FSM to DECODE_ADDRESS next cycle, clear count and parity, and assert no err or pkt_done.
REQ-027 Simultaneous events: soft_reset SHALL have priority over fifo_full, and fifo_full SHALL have priority over pkt_valid.
REQ-028 Counter width: the remaining-count SHALL be 6 bits and SHALL never wrap below 0.

Reset
REQ-029 On reset=1 at a clock edge, the state SHALL be DECODE_ADDRESS and all outputs, count, parity accumulator and held byte SHALL be 0.
REQ-030 Reset mid-packet SHALL abandon the packet, with no partial pkt_done or err.

Configuration
REQ-031 With ROUTER_PARITY_CHK_EN defined, parity SHALL be accumulated and err driven per REQ-024.
REQ-032 Without ROUTER_PARITY_CHK_EN, err SHALL be constant 0, no accumulator SHALL exist, and the parity byte SHALL still be forwarded and pkt_done still pulsed.

Structure
REQ-033 Package router_pkg SHALL hold the state enum, the address width (2), the length width (6) and the constant ADDR_INVALID=2'b11.
REQ-034 The parity accumulator SHALL be the sub-module router_parity (clear, accumulate-enable, byte in, running XOR out).

Verification
REQ-035 Normal packet: header 8'h0D (len 3, addr 1), empty_1=1, payload 11/22/33, parity = XOR of all -> four payload/parity writes plus header write, pkt_done pulse, err=0.
REQ-036 Parity error: same packet with parity 8'hFF -> err=1 for exactly one cycle, together with pkt_done.
REQ-037 Full stall: fifo_full=1 for 5 cycles after the second payload byte -> busy=1, no write during the stall, held byte rewritten once, order preserved.
REQ-038 Wait till empty: header addr 2 with empty_2=0 -> busy=1 until empty_2=1, then header written next cycle.
REQ-039 Abort and drops: soft_reset_1 mid-payload -> DECODE_ADDRESS next cycle, no pkt_done; header addr 3 -> no write, detect_add=0.
REQ-040 Boundaries: len=0 packet -> header then parity writes only; reset asserted mid-packet -> all outputs 0 next cycle.
